// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift one byte on
// device clocks, check the acknowledge, then wait for the bus to go idle.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] INH_DAT = TW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] INH_END = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_END  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, DATA, ACK, WAIT_IDLE} state_t;

    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [3:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          parity_reg, parity_next;
    logic          clk_oe_reg, clk_oe_next;
    logic          dat_oe_reg, dat_oe_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;

    logic clk_meta_reg, clk_sync_reg, clk_prev_reg;
    logic dat_meta_reg, dat_sync_reg;
    logic fall;
    logic accept;

    // Idle bus is high, so the synchronizers reset to 1 to avoid a false fall.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            clk_meta_reg <= 1'b1;
            clk_sync_reg <= 1'b1;
            clk_prev_reg <= 1'b1;
            dat_meta_reg <= 1'b1;
            dat_sync_reg <= 1'b1;
        end else begin
            clk_meta_reg <= ps2_clk_in;
            clk_sync_reg <= clk_meta_reg;
            clk_prev_reg <= clk_sync_reg;
            dat_meta_reg <= ps2_dat_in;
            dat_sync_reg <= dat_meta_reg;
        end
    end

    assign fall   = clk_prev_reg & ~clk_sync_reg;
    assign accept = tx_valid & (state_reg == IDLE);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            clk_oe_reg  <= 1'b0;
            dat_oe_reg  <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            parity_reg  <= parity_next;
            clk_oe_reg  <= clk_oe_next;
            dat_oe_reg  <= dat_oe_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg + 1'b1;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        clk_oe_next  = clk_oe_reg;
        dat_oe_next  = dat_oe_reg;
        done_next    = 1'b0;
        err_next     = 1'b0;

        // The state is held through the pulse cycle so tx_ready rises after it.
        if (done_reg || err_reg) begin
            state_next  = IDLE;
            clk_oe_next = 1'b0;
            dat_oe_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    timer_next  = '0;
                    clk_oe_next = 1'b0;
                    dat_oe_next = 1'b0;
                    if (accept) begin
                        shift_next   = tx_data;
                        parity_next  = ~^tx_data;
                        bit_cnt_next = '0;
                        clk_oe_next  = 1'b1;
                        state_next   = INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (timer_reg == INH_DAT) begin
                        dat_oe_next = 1'b1;
                    end
                    if (timer_reg == INH_END) begin
                        clk_oe_next = 1'b0;
                        timer_next  = '0;
                        state_next  = RTS;
                    end
                end
                default: begin
                    if (timer_reg == TO_END) begin
                        clk_oe_next = 1'b0;
                        dat_oe_next = 1'b0;
                        err_next    = 1'b1;
                    end else begin
                        case (state_reg)
                            RTS: begin
                                if (fall) begin
                                    bit_cnt_next = 4'd1;
                                    dat_oe_next  = ~shift_reg[0];
                                    shift_next   = {1'b0, shift_reg[7:1]};
                                    state_next   = DATA;
                                end
                            end
                            DATA: begin
                                if (fall) begin
                                    bit_cnt_next = bit_cnt_reg + 4'd1;
                                    if (bit_cnt_reg < 4'd8) begin
                                        dat_oe_next = ~shift_reg[0];
                                        shift_next  = {1'b0, shift_reg[7:1]};
                                    end else if (bit_cnt_reg == 4'd8) begin
                                        dat_oe_next = ~parity_reg;
                                    end else begin
                                        dat_oe_next = 1'b0;
                                        state_next  = ACK;
                                    end
                                end
                            end
                            ACK: begin
                                if (fall) begin
                                    bit_cnt_next = bit_cnt_reg + 4'd1;
                                    if (!dat_sync_reg) begin
                                        state_next = WAIT_IDLE;
                                    end else begin
                                        err_next = 1'b1;
                                    end
                                end
                            end
                            WAIT_IDLE: begin
                                if (clk_sync_reg && dat_sync_reg) begin
                                    done_next = 1'b1;
                                end
                            end
                            default: state_next = IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign tx_ready   = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign tx_done    = done_reg;
    assign tx_err     = err_reg;
    assign ps2_clk_oe = clk_oe_reg;
    assign ps2_dat_oe = dat_oe_reg;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA host to an attached PS/2 keyboard or mouse. It runs the full request-to-send sequence, shifts data on device-generated clocks, and checks the device acknowledge. It sits beside the existing PS/2 host receiver and shares the open-drain PS2_CLK/PS2_DAT pins with it. The top level maps each `*_oe` output to a pin as "oe ? 0 : Z".

## Interface
Parameters:
- INHIBIT_CYCLES, 5000: clock-low inhibit duration in CLOCK_50 cycles (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum cycles from end of inhibit to ack (15 ms).

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- Resetn  in  1  asynchronous, active-low reset.
- tx_data  in  8  command byte; captured on accept.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; accept = tx_valid & tx_ready.
- busy  out  1  high in every state other than IDLE.
- tx_done  out  1  one-cycle pulse: byte sent and device acked.
- tx_err  out  1  one-cycle pulse: no ack (data sampled high) or timeout.
- ps2_clk_in  in  1  PS2_CLK pin level (asynchronous).
- ps2_dat_in  in  1  PS2_DAT pin level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.

## Operation
- ps2_clk_in and ps2_dat_in each pass through a 2-flop synchronizer.
- fall = synced clock was 1 on the previous cycle and is 0 now.
- On accept, latch tx_data into a shift register and compute odd parity: parity = ~^tx_data.
- State machine:
  - IDLE: both oe = 0. On accept, go to INHIBIT.
  - INHIBIT: clk_oe = 1 for INHIBIT_CYCLES cycles. On the last cycle, set dat_oe = 1 (start bit 0), then go to RTS.
  - RTS: clk_oe = 0, dat_oe = 1. Start the timeout counter. Wait for fall.
  - DATA: falls 1–8 drive bits 0–7, LSB first, with dat_oe = ~bit. Fall 9 drives parity. Fall 10 sets dat_oe = 0 (stop bit, line released). Then go to ACK.
  - ACK: on fall 11, sample synced data. If 0, go to WAIT_IDLE. If 1, pulse tx_err and go to IDLE.
  - WAIT_IDLE: wait until synced clock and data are both 1. Then pulse tx_done and go to IDLE.
- The bit/edge counter is 4 bits and clears on accept.
- Timeout: the counter runs from RTS entry through WAIT_IDLE. When it reaches TIMEOUT_CYCLES−1:
  - both oe go to 0,
  - tx_err pulses,
  - state returns to IDLE.
- Timeout takes priority over a fall in the same cycle.
- tx_valid outside IDLE is ignored; the byte is not queued.
- tx_done and tx_err are never high in the same cycle.

## Timing
- Reset values (asynchronous, immediate): state IDLE, tx_ready = 1, busy = 0, tx_done = 0, tx_err = 0, ps2_clk_oe = 0, ps2_dat_oe = 0.
- Reset mid-transfer releases both lines in the same instant; the transfer is abandoned with no pulse.
- All outputs are registered except tx_ready and busy, which decode the state register.
- Accept in cycle N:
  - busy and ps2_clk_oe high from N+1,
  - ps2_clk_oe stays high for exactly INHIBIT_CYCLES cycles,
  - ps2_dat_oe rises on the last of those cycles, while ps2_clk_oe is still high.
- Each data, parity or stop change to ps2_dat_oe occurs 3 cycles after the raw pin falls (2 sync stages plus 1 register). The device samples on the rising edge, ≥30 µs later.
- tx_done pulses 1 cycle after both synced lines read high following an ack.
- tx_ready returns high in the cycle after the tx_done or tx_err pulse.

## Test plan
- Send 0xED; a bench device model clocks at 12.5 kHz and acks. Required:
  - clk_oe high exactly 5000 cycles,
  - data bits observed at device rising edges are 1,0,1,1,0,1,1,1, then parity 1, then stop 1,
  - one tx_done pulse, no tx_err.
- Send 0xF4 (5 ones): parity bit observed 0. Send 0x00: parity bit observed 1.
- Device holds data high at the ack clock -> one tx_err pulse, no tx_done, both oe = 0, tx_ready = 1 the next cycle.
- Device never clocks after RTS -> tx_err exactly TIMEOUT_CYCLES cycles after RTS entry, both lines released.
- Assert Resetn low during the 5th data bit -> both oe = 0 immediately, state IDLE. A new 0xFF sent after reset completes with tx_done.
- Pulse tx_valid with 0x55 during a transfer of 0xF4 -> only 0xF4 is transmitted; exactly one tx_done.
